// File: rtl/handshake_fifo_buffer.sv
// Elastic FIFO on a valid/ready channel. It registers both the forward
// (valid/data) path and the backward (ready) path, so producer and consumer
// are fully decoupled. Tokens come out in arrival order, one cycle after they
// are accepted. Depth may be any value from 2 to 64, including non-powers of two.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    next_ptr = (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Handshakes are decoded from registered occupancy only; ready also drops
  // while reset is held so nothing is accepted during reset.
  assign ins_ready  = rst && (count != FULL_CNT);
  assign outs_valid = (count != '0);
  assign push       = ins_valid && ins_ready;
  assign pop        = outs_valid && outs_ready;

  // Gate the head so uninitialised storage never shows up on the output.
  assign outs = outs_valid ? mem[rd_ptr] : '0;

  // Storage array: written on push, never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ins;
  end

  // Pointer and occupancy bookkeeping; reset clears all control state at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Bench for handshake_fifo_buffer: a depth-4 and a depth-3 instance are
// driven side by side and compared every cycle against queue-based models.
module tb_handshake_fifo_buffer;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] a_ins, a_outs;
  logic        a_ins_valid, a_ins_ready, a_outs_valid, a_outs_ready;
  logic [31:0] b_ins, b_outs;
  logic        b_ins_valid, b_ins_ready, b_outs_valid, b_outs_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          b_in_cnt  = 0;
  int          b_out_cnt = 0;

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut_a (
    .clk(clk), .rst(rst),
    .ins(a_ins), .ins_valid(a_ins_valid), .ins_ready(a_ins_ready),
    .outs(a_outs), .outs_valid(a_outs_valid), .outs_ready(a_outs_ready)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst(rst),
    .ins(b_ins), .ins_valid(b_ins_valid), .ins_ready(b_ins_ready),
    .outs(b_outs), .outs_valid(b_outs_valid), .outs_ready(b_outs_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: decide handshakes from the model's pre-edge occupancy and the
  // current inputs, advance the models at the edge, then compare outputs.
  task automatic cycle();
    bit          pa, pb, oa, ob;
    logic [31:0] da, db;
    pa = rst && a_ins_valid && (qa.size() < 4);
    oa = rst && a_outs_ready && (qa.size() != 0);
    pb = rst && b_ins_valid && (qb.size() < 3);
    ob = rst && b_outs_ready && (qb.size() != 0);
    da = a_ins;
    db = b_ins;
    @(posedge clk);
    if (oa) void'(qa.pop_front());
    if (pa) qa.push_back(da);
    if (ob) begin void'(qb.pop_front()); b_out_cnt++; end
    if (pb) begin qb.push_back(db); b_in_cnt++; end
    #1;
    check_eq("a_outs_valid", a_outs_valid, qa.size() != 0);
    check_eq("a_ins_ready", a_ins_ready, rst && (qa.size() < 4));
    if (qa.size() != 0) check_eq("a_outs", a_outs, qa[0]);
    check_eq("b_outs_valid", b_outs_valid, qb.size() != 0);
    check_eq("b_ins_ready", b_ins_ready, rst && (qb.size() < 3));
    if (qb.size() != 0) check_eq("b_outs", b_outs, qb[0]);
    check_eq("b_wr_ptr_range", dut_b.wr_ptr < 2'd3, 1);
    check_eq("b_rd_ptr_range", dut_b.rd_ptr < 2'd3, 1);
  endtask

  initial begin
    rst = 1'b0;
    a_ins = '0; a_ins_valid = 1'b0; a_outs_ready = 1'b0;
    b_ins = '0; b_ins_valid = 1'b0; b_outs_ready = 1'b0;

    // Reset held for three cycles
    #1;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("rst_ready", a_ins_ready, 0);
    check_eq("rst_count", dut_a.count, 0);

    // Release with consumer ready; ready must rise without waiting for an edge
    a_outs_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("rel_ready", a_ins_ready, 1);
    check_eq("rel_valid", a_outs_valid, 0);
    a_ins = 32'h3; a_ins_valid = 1'b1;
    cycle();
    check_eq("single_valid", a_outs_valid, 1);
    check_eq("single_data", a_outs, 32'h3);
    a_ins_valid = 1'b0;
    cycle();
    check_eq("single_gone", a_outs_valid, 0);

    // Fill and drain, then a blocked fifth push
    a_outs_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      a_ins = v; a_ins_valid = 1'b1;
      cycle();
    end
    check_eq("full_ready", a_ins_ready, 0);
    a_ins = 32'd5;
    cycle();
    check_eq("full_count", dut_a.count, 4);
    a_ins_valid = 1'b0;
    a_outs_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      check_eq("drain_data", a_outs, v);
      cycle();
    end
    check_eq("drain_empty", a_outs_valid, 0);

    // Simultaneous push/pop holding two tokens
    a_outs_ready = 1'b0;
    for (int v = 100; v < 102; v++) begin
      a_ins = v; a_ins_valid = 1'b1;
      cycle();
    end
    a_outs_ready = 1'b1;
    for (int v = 10; v < 20; v++) begin
      a_ins = v;
      cycle();
      check_eq("stream_count", dut_a.count, 2);
    end
    a_ins_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Full-pop bubble
    a_outs_ready = 1'b0;
    for (int v = 20; v < 24; v++) begin
      a_ins = v; a_ins_valid = 1'b1;
      cycle();
    end
    a_ins = 32'd24; a_outs_ready = 1'b1;
    check_eq("bubble_ready0", a_ins_ready, 0);
    cycle();
    check_eq("bubble_count", dut_a.count, 3);
    check_eq("bubble_ready1", a_ins_ready, 1);
    cycle();
    check_eq("bubble_accept", dut_a.count, 3);
    a_ins_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Randomized traffic on both depths until the depth-3 buffer has
    // delivered enough tokens to wrap several times
    begin
      int budget = 0;
      while ((b_out_cnt < 12 || budget < 60) && budget < 600) begin
        a_ins = $urandom; a_ins_valid = $urandom_range(0, 1);
        a_outs_ready = $urandom_range(0, 1);
        b_ins = $urandom; b_ins_valid = $urandom_range(0, 1);
        b_outs_ready = $urandom_range(0, 1);
        cycle();
        budget++;
      end
      check_eq("random_progress", b_out_cnt >= 12, 1);
    end

    // Mid-operation reset with three tokens stored
    a_ins_valid = 1'b0; b_ins_valid = 1'b0;
    a_outs_ready = 1'b1; b_outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    a_outs_ready = 1'b0;
    for (int v = 40; v < 43; v++) begin
      a_ins = v; a_ins_valid = 1'b1;
      cycle();
    end
    a_ins_valid = 1'b0;
    check_eq("pre_rst_count", dut_a.count, 3);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", a_outs_valid, 0);
    check_eq("mid_rst_ready", a_ins_ready, 0);
    check_eq("mid_rst_count", dut_a.count, 0);
    qa.delete();
    qb.delete();
    #1 rst = 1'b1;
    #1;
    check_eq("post_rst_ready", a_ins_ready, 1);
    a_outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    a_ins = 32'd77; a_ins_valid = 1'b1;
    cycle();
    check_eq("post_rst_data", a_outs, 32'd77);
    a_ins_valid = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_buffer.md
# handshake_fifo_buffer

Opaque elastic FIFO buffer on a dataflow handshake channel. It sits directly downstream of constant and other zero-latency handshake units and absorbs their tokens: it breaks the valid/data path and the ready path between producer and consumer. Each accepted token is stored and presented one cycle later, in strict order. It is sized by `NUM_SLOTS` so slack can be tuned per channel.

## Interface
- `DATA_WIDTH`, 32: token width in bits.
- `NUM_SLOTS`, 4: storage depth in tokens. Legal range is 2..64.

- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous, active-low. 0 clears all state immediately.
- `ins`  input  DATA_WIDTH  input token data.
- `ins_valid`  input  1  input token present.
- `ins_ready`  output  1  buffer can accept a token this cycle.
- `outs`  output  DATA_WIDTH  head token data.
- `outs_valid`  output  1  head token present.
- `outs_ready`  input  1  consumer accepts head token.

## Operation
- Storage is a register array `mem[0..NUM_SLOTS-1]`, plus:
  - head pointer `rd_ptr`,
  - tail pointer `wr_ptr`,
  - occupancy `count`, range 0..NUM_SLOTS, width clog2(NUM_SLOTS+1).
- Push occurs when `ins_valid && ins_ready`: write `mem[wr_ptr] <= ins`, then advance `wr_ptr`.
- Pop occurs when `outs_valid && outs_ready`: advance `rd_ptr`.
- Pointer wrap: a pointer equal to NUM_SLOTS-1 advances to 0. This holds for non-power-of-two depths as well.
- Occupancy states, derived from `count`:
  - EMPTY (`count == 0`)
  - PARTIAL (`0 < count < NUM_SLOTS`)
  - FULL (`count == NUM_SLOTS`)
- State transitions:
  - push only: count +1
  - pop only: count −1
  - push and pop together: count unchanged, both pointers advance
  - neither: hold
- Output decode:
  - `ins_ready = rst && (count != NUM_SLOTS)`
  - `outs_valid = (count != 0)`
  - `outs = mem[rd_ptr]`
- Both `ins_ready` and `outs_valid` are decoded from registered state only. There is no combinational path from `outs_ready` to `ins_ready`, nor from `ins_valid`/`ins` to `outs_valid`/`outs`.
- FULL with `outs_ready=1`: the pop happens, but `ins_ready` is 0 in that cycle, so no push occurs. The following cycle `ins_ready` returns to 1.
- EMPTY: `outs_valid=0`, and `outs_ready` is ignored. An incoming token is not bypassed.
- `outs` value while `outs_valid=0` is don't-care; the implementation must not generate X from uninitialised memory after reset.
- Data is never reordered, duplicated or dropped.

## Timing
- Reset assertion (`rst=0`), asynchronously and without waiting for a clock edge:
  - `count=0`, `rd_ptr=0`, `wr_ptr=0`
  - `outs_valid=0`, `ins_ready=0`
  - `mem` contents are not reset (don't-care).
- Reset release: `ins_ready=1` as soon as `rst=1`. The first push can occur on the first rising edge after release.
- Latency: a token pushed at edge N has `outs_valid=1` and `outs` equal to that token from edge N until it is popped. This is one cycle of latency measured from the push cycle.
- Throughput: one token per cycle sustained in PARTIAL with both sides active. The FULL→pop cycle costs one input bubble.
- Handshake rules:
  - Once `outs_valid=1`, it stays 1 and `outs` stays stable until the pop.
  - The producer may drop `ins_valid` at any time; only cycles with `ins_valid && ins_ready` count as pushes.
- Reset asserted mid-operation: all stored tokens are discarded, and outputs go to reset values immediately.

## Test plan
- Reset, single token:
  - Hold `rst=0` 3 cycles, then release with `outs_ready=1`; push `ins=32'h00000003` for one cycle.
  - Required response: `ins_ready=0` during reset; after release `ins_ready=1` and `outs_valid=0`; next cycle `outs_valid=1`, `outs=3`; the cycle after, `outs_valid=0`.
- Fill and drain:
  - With `NUM_SLOTS=4` and `outs_ready=0`, push 1,2,3,4, then attempt to push 5.
  - Required response: `ins_ready=0` after the 4th push, and 5 is not accepted.
  - Then set `outs_ready=1`: outputs 1,2,3,4 appear on consecutive cycles, after which `outs_valid=0`.
- Simultaneous push/pop:
  - Hold `count=2`; push 10..19 continuously with `outs_ready=1`.
  - Required response: `count` stays 2; outputs appear in order, one per cycle, with no bubbles.
- Full-pop bubble:
  - Reach FULL, then assert `outs_ready=1` and `ins_valid=1`.
  - Required response: first cycle pops with `ins_ready=0`; next cycle `ins_ready=1` and the push is accepted.
- Wrap-around at odd depth:
  - With `NUM_SLOTS=3`, push and pop 10 tokens under random `ins_valid`/`outs_ready`.
  - Required response: output sequence identical to the input sequence; pointers wrap 2→0.
- Mid-operation reset:
  - With `count=3`, pulse `rst=0` between clock edges.
  - Required response: `outs_valid=0` immediately; after release the buffer is EMPTY and the old tokens are never output.
